codec_sample_receiver: RTL and testbench

Receive-side counterpart to the codec conditioner. It turns the codec's raw `new_frame` strobe and incoming 16-bit ADC sample into buffered samples, one per frame, with a valid/ack handshake toward the music-side logic. It sits between the ac97_if codec interface and any consumer of recorded audio (for example record/playback or an effects path). It absorbs consumer stalls with a small FIFO and flags overflow.

---
 rtl/codec_sample_receiver_pkg.sv | 20 ++
 rtl/codec_sample_receiver_fifo.sv | 54 +++++
 rtl/codec_sample_receiver.sv | 66 ++++++
 tb/tb_codec_sample_receiver.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/codec_sample_receiver_pkg.sv
// Shared audio definitions: sample width/type and FIFO operation decoding
// used by the codec-side receive path.
package codec_sample_receiver_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic push, input logic pop);
    return fifo_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/codec_sample_receiver_fifo.sv
// Show-ahead sample FIFO; full/empty come from the occupancy counter so the
// pointers can simply wrap modulo DEPTH.
module sample_fifo
  import codec_sample_receiver_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  sample_t         wdata,
  output sample_t         rdata,
  output logic [ADDR_W:0] level,
  output logic            full,
  output logic            empty
);

  sample_t           mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == (ADDR_W + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO only lands if the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case (fifo_op(do_push, do_pop))
        OP_PUSH: level <= level + 1'b1;
        OP_POP:  level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign rdata = empty ? sample_t'(0) : mem[rd_ptr];

endmodule

// File: rtl/codec_sample_receiver.sv
// Codec receive path: frame edge detection, capture gating, sticky overflow
// and a buffered valid/ack sample stream toward the music-side logic.
module codec_sample_receiver
  import codec_sample_receiver_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       new_frame,
  input  logic signed [SAMPLE_W-1:0] adc_sample,
  input  logic                       enable,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_valid,
  input  logic                       sample_ack,
  output logic [ADDR_W:0]            level,
  output logic                       overflow,
  input  logic                       clear_overflow,
  output logic                       frame_pulse
);

  logic nf_d;
  logic frame_edge;
  logic push;
  logic pop;
  logic full;
  logic empty;
  logic drop;

  assign frame_edge   = new_frame & ~nf_d;
  assign push         = frame_edge & enable;
  assign sample_valid = ~empty;
  assign pop          = sample_ack & sample_valid;
  assign drop         = push & full & ~pop;

  // nf_d resets high so a strobe already asserted at release is not a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      nf_d        <= 1'b1;
      frame_pulse <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      nf_d        <= new_frame;
      frame_pulse <= frame_edge;
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  sample_fifo #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .wdata(adc_sample),
    .rdata(sample_out),
    .level(level),
    .full (full),
    .empty(empty)
  );

endmodule

// File: tb/tb_codec_sample_receiver.sv
// Scoreboard bench for codec_sample_receiver: stimulus queues expected samples,
// a forked monitor checks every popped head sample against the queue.
module tb_codec_sample_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_frame;
  logic [15:0] adc_sample;
  logic        enable;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        sample_ack;
  logic [3:0]  level;
  logic        overflow;
  logic        clear_overflow;
  logic        frame_pulse;

  int          vectors = 0;
  int          errors  = 0;
  int          fp_count = 0;
  int          fp_base;
  int          mlevel;
  logic        nf_prev;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  codec_sample_receiver #(.DEPTH(8), .ADDR_W(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .new_frame     (new_frame),
    .adc_sample    (adc_sample),
    .enable        (enable),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .sample_ack    (sample_ack),
    .level         (level),
    .overflow      (overflow),
    .clear_overflow(clear_overflow),
    .frame_pulse   (frame_pulse)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sampled on the falling edge: an ack seen here pops the head at the next rise.
  task automatic monitor();
    logic [15:0] exp_v;
    forever begin
      @(negedge clk);
      if (frame_pulse) fp_count++;
      if (!reset && sample_valid && sample_ack) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL pop_unexpected: got %0h expected no sample at %0t", sample_out, $time);
        end else begin
          exp_v = exp_q.pop_front();
          chk("pop_data", {16'h0, sample_out}, {16'h0, exp_v});
        end
      end
    end
  endtask

  task automatic frame(input logic [15:0] s, input int hold, input logic clr);
    new_frame      = 1'b1;
    adc_sample     = s;
    clear_overflow = clr;
    tick();
    clear_overflow = 1'b0;
    repeat (hold - 1) tick();
    new_frame = 1'b0;
    tick();
  endtask

  task automatic drain(input int n);
    sample_ack = 1'b1;
    repeat (n) tick();
    sample_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; new_frame = 1'b0; adc_sample = 16'h0; enable = 1'b0;
    sample_ack = 1'b0; clear_overflow = 1'b0;
    fork
      monitor();
      begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset values, with new_frame high across the release.
    repeat (2) tick();
    chk("rst_level", level, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_sample_out", sample_out, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_pulse", frame_pulse, 0);
    new_frame = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    new_frame = 1'b0;
    repeat (2) tick();
    chk("held_level", level, 0);
    chk("held_valid", sample_valid, 0);
    chk("held_sample_out", sample_out, 0);
    chk("held_pulses", fp_count, 0);

    // Three long frames, no ack, then three acks.
    enable = 1'b1;
    exp_q.push_back(16'h0001); frame(16'h0001, 4, 1'b0);
    exp_q.push_back(16'h8000); frame(16'h8000, 4, 1'b0);
    exp_q.push_back(16'h7FFF); frame(16'h7FFF, 4, 1'b0);
    chk("three_level", level, 3);
    chk("three_head", sample_out, 16'h0001);
    chk("three_pulses", fp_count, 3);
    drain(3);
    chk("three_drained_valid", sample_valid, 0);
    chk("three_drained_out", sample_out, 0);

    // Ten frames into an 8-deep FIFO; the last two are dropped.
    for (int i = 0; i < 10; i++) begin
      if (i < 8) exp_q.push_back(16'(i));
      frame(16'(i), 2, 1'b0);
    end
    chk("ovf_level", level, 8);
    chk("ovf_flag", overflow, 1);
    frame(16'd10, 2, 1'b1);
    chk("ovf_set_wins", overflow, 1);
    chk("ovf_level_kept", level, 8);
    drain(8);
    chk("ovf_drained_level", level, 0);
    chk("ovf_sticky", overflow, 1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // Full FIFO with a frame edge and an ack in the same cycle.
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(16'(32 + i));
      frame(16'(32 + i), 2, 1'b0);
    end
    chk("full_level", level, 8);
    new_frame = 1'b1;
    adc_sample = 16'h0100;
    sample_ack = 1'b1;
    exp_q.push_back(16'h0100);
    tick();
    sample_ack = 1'b0;
    tick();
    new_frame = 1'b0;
    tick();
    chk("full_pp_level", level, 8);
    chk("full_pp_overflow", overflow, 0);
    drain(8);
    chk("full_pp_drained", level, 0);

    // Capture disabled: pulses still fire, nothing is stored.
    enable = 1'b0;
    fp_base = fp_count;
    for (int i = 0; i < 5; i++) frame(16'h00AA, 2, 1'b0);
    chk("dis_pulses", fp_count - fp_base, 5);
    chk("dis_level", level, 0);
    chk("dis_overflow", overflow, 0);
    drain(2);
    chk("empty_ack_level", level, 0);
    chk("empty_ack_valid", sample_valid, 0);

    // Frames every other cycle with a random ack stall pattern.
    enable = 1'b1;
    nf_prev = 1'b0;
    mlevel = 0;
    for (int c = 0; c < 40; c++) begin
      logic nf, ack, edge_m, pop_m, push_m;
      nf = (c % 2 == 0);
      ack = 1'($urandom_range(0, 1));
      new_frame = nf;
      adc_sample = 16'h1000 + 16'(c / 2);
      sample_ack = ack;
      edge_m = nf & ~nf_prev;
      pop_m = ack && (mlevel > 0);
      push_m = edge_m && ((mlevel < 8) || pop_m);
      if (push_m) exp_q.push_back(adc_sample);
      mlevel = mlevel + int'(push_m) - int'(pop_m);
      nf_prev = nf;
      tick();
      chk("rand_level", level, 32'(mlevel));
    end
    sample_ack = 1'b0;
    new_frame = 1'b0;
    tick();
    drain(10);
    chk("rand_drained", level, 0);

    // Reset mid-stream discards contents; next edge is captured.
    exp_q.push_back(16'h00A1); frame(16'h00A1, 2, 1'b0);
    exp_q.push_back(16'h00A2); frame(16'h00A2, 2, 1'b0);
    chk("pre_rst_level", level, 2);
    reset = 1'b1;
    tick();
    exp_q.delete();
    chk("mid_rst_level", level, 0);
    chk("mid_rst_valid", sample_valid, 0);
    chk("mid_rst_out", sample_out, 0);
    reset = 1'b0;
    tick();
    exp_q.push_back(16'h0055); frame(16'h0055, 2, 1'b0);
    chk("post_rst_level", level, 1);
    chk("post_rst_head", sample_out, 16'h0055);
    drain(1);
    chk("post_rst_drained", level, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
